// File: rtl/dct_pkg.sv
// Shared types and helpers for the row/column 2-D DCT sequencer.
package dct_pkg;

  localparam int DCT_N  = 8;
  localparam int CNT_W  = 4;
  localparam int WIDE_W = 65;

  typedef enum logic {S_ROW, S_COL} dctseq_state_t;

  // Round-half-up arithmetic right shift; callers truncate the result to their data width.
  function automatic logic signed [WIDE_W-1:0] round_shift(input logic signed [WIDE_W-1:0] v,
                                                           input int s);
    logic signed [WIDE_W-1:0] half;
    if (s == 0) return v;
    half = WIDE_W'(1) << (s - 1);
    return (v + half) >>> s;
  endfunction

endpackage

// File: rtl/dct2d_row_col_seq_if.sv
// Upstream row stream, downstream column stream and shared-core attachment of the DCT sequencer.
interface dct2d_row_col_seq_if #(parameter int IN_W = 32);
  import dct_pkg::*;

  localparam int VEC_W = DCT_N * IN_W;

  logic             in_valid;
  logic             in_ready;
  logic [VEC_W-1:0] in_row;
  logic             out_valid;
  logic             out_ready;
  logic [VEC_W-1:0] out_col;
  logic [2:0]       out_idx;
  logic             out_last;
  logic             core_in_valid;
  logic             core_in_ready;
  logic [VEC_W-1:0] core_in;
  logic             core_out_valid;
  logic             core_out_ready;
  logic [VEC_W-1:0] core_out;

  modport master (
    input  in_valid, in_row, out_ready, core_in_ready, core_out_valid, core_out,
    output in_ready, out_valid, out_col, out_idx, out_last, core_in_valid, core_in, core_out_ready
  );

  modport slave (
    output in_valid, in_row, out_ready, core_in_ready, core_out_valid, core_out,
    input  in_ready, out_valid, out_col, out_idx, out_last, core_in_valid, core_in, core_out_ready
  );

endinterface

// File: rtl/dct_tbuf_8x8.sv
// 8x8 transpose buffer: whole-row writes, combinational whole-column reads.
module dct_tbuf_8x8
  import dct_pkg::*;
#(
  parameter int IN_W = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [2:0]            waddr,
  input  logic [DCT_N*IN_W-1:0] wrow,
  input  logic [2:0]            raddr,
  output logic [DCT_N*IN_W-1:0] rcol
);

  logic [IN_W-1:0] mem [DCT_N][DCT_N];

  // NOTE: the array has no reset; every entry is written by a row pass before any column read uses it.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int c = 0; c < DCT_N; c++) mem[waddr][c] <= wrow[c*IN_W +: IN_W];
    end
  end

  always_comb begin
    rcol = '0;
    for (int k = 0; k < DCT_N; k++) rcol[k*IN_W +: IN_W] = mem[k][raddr];
  end

endmodule

// File: rtl/dct2d_row_col_seq.sv
// Drives one shared 1-D DCT core through 8 row passes into a transpose buffer, then 8 column passes out.
module dct2d_row_col_seq
  import dct_pkg::*;
#(
  parameter int IN_W      = 32,
  parameter int ROW_SHIFT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  dct2d_row_col_seq_if.master bus,
  output logic                busy
);

  localparam int VEC_W = DCT_N * IN_W;

  dctseq_state_t    state;
  logic [CNT_W-1:0] iss_cnt;
  logic [CNT_W-1:0] done_cnt;
  logic             row_phase;
  logic             iss_open;
  logic             in_hs;
  logic             res_hs;
  logic             res_last;
  logic [VEC_W-1:0] wrow;
  logic [VEC_W-1:0] rcol;

  // NOTE: every signal written here gets a value on every path, so no latches are inferred.
  always_comb begin
    row_phase          = (state == S_ROW);
    iss_open           = (iss_cnt < CNT_W'(DCT_N));
    bus.in_ready       = row_phase && bus.core_in_ready && iss_open;
    bus.core_in_valid  = rst_n && iss_open && (row_phase ? bus.in_valid : 1'b1);
    bus.core_in        = row_phase ? bus.in_row : rcol;
    bus.core_out_ready = row_phase || bus.out_ready;
    bus.out_valid      = !row_phase && bus.core_out_valid;
    bus.out_col        = bus.core_out;
    bus.out_idx        = done_cnt[2:0];
    bus.out_last       = !row_phase && (done_cnt == CNT_W'(DCT_N - 1));
    in_hs              = bus.core_in_valid && bus.core_in_ready;
    res_hs             = bus.core_out_valid && bus.core_out_ready;
    res_last           = res_hs && (done_cnt == CNT_W'(DCT_N - 1));
    busy               = !row_phase || (iss_cnt != '0) || (done_cnt != '0);
  end

  // Row results are rounded before they land in the buffer; column results pass through untouched.
  always_comb begin
    wrow = '0;
    for (int c = 0; c < DCT_N; c++) begin
      wrow[c*IN_W +: IN_W] = IN_W'(round_shift(WIDE_W'(signed'(bus.core_out[c*IN_W +: IN_W])),
                                               ROW_SHIFT));
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_ROW;
      iss_cnt  <= '0;
      done_cnt <= '0;
    end else if (res_last) begin
      state    <= row_phase ? S_COL : S_ROW;
      iss_cnt  <= '0;
      done_cnt <= '0;
    end else begin
      if (in_hs)  iss_cnt  <= iss_cnt + 1'b1;
      if (res_hs) done_cnt <= done_cnt + 1'b1;
    end
  end

  dct_tbuf_8x8 #(.IN_W(IN_W)) u_tbuf (
    .clk   (clk),
    .we    (row_phase && res_hs),
    .waddr (done_cnt[2:0]),
    .wrow  (wrow),
    .raddr (iss_cnt[2:0]),
    .rcol  (rcol)
  );

endmodule

// File: tb/tb_dct2d_row_col_seq.sv
// Two sequencer instances (ROW_SHIFT 0 and 1) share one stimulus path and one model core; a matrix-level model checks every beat.
module tb_dct2d_row_col_seq;
  import dct_pkg::*;

  localparam int IN_W  = 32;
  localparam int VEC_W = DCT_N * IN_W;

  typedef logic [VEC_W-1:0] vec_t;
  typedef struct { vec_t data; int due; } core_txn_t;
  typedef struct { vec_t col; int idx; } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic lane = 1'b0;
  logic in_valid = 1'b0;
  vec_t in_row = '0;
  logic out_ready = 1'b1;
  logic core_in_ready = 1'b1;
  logic core_out_valid = 1'b0;
  vec_t core_out = '0;
  logic busy0, busy1;

  dct2d_row_col_seq_if #(.IN_W(IN_W)) bus0 ();
  dct2d_row_col_seq_if #(.IN_W(IN_W)) bus1 ();

  dct2d_row_col_seq #(.IN_W(IN_W), .ROW_SHIFT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0), .busy(busy0));
  dct2d_row_col_seq #(.IN_W(IN_W), .ROW_SHIFT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1));

  assign bus0.in_valid       = in_valid && !lane;
  assign bus1.in_valid       = in_valid && lane;
  assign bus0.in_row         = in_row;
  assign bus1.in_row         = in_row;
  assign bus0.out_ready      = out_ready || lane;
  assign bus1.out_ready      = out_ready || !lane;
  assign bus0.core_in_ready  = core_in_ready && !lane;
  assign bus1.core_in_ready  = core_in_ready && lane;
  assign bus0.core_out_valid = core_out_valid && !lane;
  assign bus1.core_out_valid = core_out_valid && lane;
  assign bus0.core_out       = core_out;
  assign bus1.core_out       = core_out;

  logic m_in_ready, m_out_valid, m_out_last, m_core_in_valid, m_core_out_ready, m_busy;
  logic [2:0] m_out_idx;
  vec_t m_out_col, m_core_in;
  assign m_in_ready       = lane ? bus1.in_ready       : bus0.in_ready;
  assign m_out_valid      = lane ? bus1.out_valid      : bus0.out_valid;
  assign m_out_col        = lane ? bus1.out_col        : bus0.out_col;
  assign m_out_idx        = lane ? bus1.out_idx        : bus0.out_idx;
  assign m_out_last       = lane ? bus1.out_last       : bus0.out_last;
  assign m_core_in_valid  = lane ? bus1.core_in_valid  : bus0.core_in_valid;
  assign m_core_in        = lane ? bus1.core_in        : bus0.core_in;
  assign m_core_out_ready = lane ? bus1.core_out_ready : bus0.core_out_ready;
  assign m_busy           = lane ? busy1 : busy0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_int(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input vec_t act, input vec_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired or event unexpected (t=%0t)", name, $time);
  endtask

  function automatic longint el(input vec_t v, input int i);
    return longint'($signed(v[i*IN_W +: IN_W]));
  endfunction

  function automatic vec_t put(input vec_t v, input int i, input longint x);
    vec_t r = v;
    r[i*IN_W +: IN_W] = x[IN_W-1:0];
    return r;
  endfunction

  function automatic vec_t splat(input longint x);
    vec_t r = '0;
    for (int i = 0; i < DCT_N; i++) r = put(r, i, x);
    return r;
  endfunction

  // Orthonormal 8-point DCT-II, rounded to nearest.
  function automatic vec_t dct8(input vec_t x);
    vec_t y = '0;
    real  s;
    for (int k = 0; k < DCT_N; k++) begin
      s = 0.0;
      for (int n = 0; n < DCT_N; n++)
        s += real'(el(x, n)) * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
      s *= (k == 0) ? $sqrt(0.125) : 0.5;
      y = put(y, k, (s >= 0.0) ? longint'($rtoi($floor(s + 0.5))) : -longint'($rtoi($floor(-s + 0.5))));
    end
    return y;
  endfunction

  bit core_dct = 1'b0;
  function automatic vec_t core_fn(input vec_t x);
    return core_dct ? dct8(x) : x;
  endfunction

  // Floor division of (v + d/2) by d = 2^s.
  function automatic longint round_model(input longint v, input int s);
    longint d, t, q;
    if (s == 0) return v;
    d = longint'(1) << s;
    t = v + d / 2;
    q = t / d;
    if ((t % d) != 0 && t < 0) q = q - 1;
    return q;
  endfunction

  // ---------------- model core ----------------
  int lat_min = 0, lat_max = 0, depth = 8, stall_pct = 0, cyc = 0;
  core_txn_t cq[$];

  always @(posedge clk) begin
    if (!rst_n) cq.delete();
    else begin
      if (core_out_valid && m_core_out_ready) void'(cq.pop_front());
      if (m_core_in_valid && core_in_ready)
        cq.push_back('{core_fn(m_core_in), cyc + 1 + int'($urandom_range(lat_min, lat_max))});
    end
    cyc++;
    #1;
    core_out_valid = rst_n && cq.size() > 0 && cq[0].due <= cyc;
    core_out       = (cq.size() > 0) ? cq[0].data : '0;
    core_in_ready  = (cq.size() < depth) && (int'($urandom_range(0, 99)) >= stall_pct);
  end

  // ---------------- downstream ready ----------------
  int  out_mode = 0;
  int  stall_left = 0;
  bit  stall_armed = 1'b0;
  always @(posedge clk) begin
    #2;
    case (out_mode)
      1: out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (stall_armed && m_out_valid && m_out_idx == 3'd3) stall_armed = 1'b0;
        if (!stall_armed && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else out_ready = 1'b1;
      end
      default: out_ready = 1'b1;
    endcase
  end

  // ---------------- reference model and compare ----------------
  vec_t  rows_q[$];
  beat_t exp_q[$];
  vec_t  got[DCT_N];
  int    beats = 0;
  int    stall_cycles = 0;
  bit    prev_stall = 1'b0;
  bit    prev_last = 1'b0;
  vec_t  prev_col;
  logic [2:0] prev_idx;

  task automatic build_expected();
    vec_t rr[DCT_N];
    vec_t y, col;
    int   sh = lane ? 1 : 0;
    for (int r = 0; r < DCT_N; r++) begin
      y = core_fn(rows_q[r]);
      rr[r] = '0;
      for (int c = 0; c < DCT_N; c++) rr[r] = put(rr[r], c, round_model(el(y, c), sh));
    end
    for (int c = 0; c < DCT_N; c++) begin
      col = '0;
      for (int k = 0; k < DCT_N; k++) col = put(col, k, el(rr[k], c));
      exp_q.push_back('{core_fn(col), c});
    end
  endtask

  always @(negedge clk) begin
    beat_t b;
    if (!rst_n) begin
      check_int("out_valid_in_reset", m_out_valid, 0);
      rows_q.delete();
      exp_q.delete();
      prev_stall = 1'b0;
      prev_last  = 1'b0;
    end else begin
      if (prev_last) check_int("busy_after_last", m_busy, 0);
      prev_last = 1'b0;
      if (in_valid && m_in_ready) begin
        rows_q.push_back(in_row);
        if (rows_q.size() == DCT_N) begin
          build_expected();
          rows_q.delete();
        end
      end
      if (prev_stall) begin
        check_int("stall_valid_held", m_out_valid, 1);
        check_vec("stall_col_stable", m_out_col, prev_col);
        check_int("stall_idx_stable", m_out_idx, prev_idx);
      end
      prev_stall = 1'b0;
      if (m_out_valid) begin
        if (!out_ready) begin
          check_int("core_out_ready_in_stall", m_core_out_ready, 0);
          prev_stall = 1'b1;
          prev_col   = m_out_col;
          prev_idx   = m_out_idx;
          stall_cycles++;
        end else if (exp_q.size() == 0) begin
          fail_now("unexpected_out_beat");
        end else begin
          b = exp_q.pop_front();
          check_vec("out_col", m_out_col, b.col);
          check_int("out_idx", m_out_idx, b.idx);
          check_int("out_last", m_out_last, b.idx == 7);
          got[b.idx] = m_out_col;
          beats++;
          if (m_out_last) prev_last = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rows(input vec_t rows[DCT_N], input int n, output int cycles);
    bit hs;
    cycles = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_row   = rows[i];
      do begin
        @(negedge clk);
        hs = m_in_ready;
        tick();
        cycles++;
        if (cycles > 3000) begin
          fail_now("row_accept_timeout");
          in_valid = 1'b0;
          return;
        end
      end while (!hs);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || m_busy) && t < 3000) begin
      tick();
      t++;
    end
    if (t >= 3000) fail_now("drain_timeout");
  endtask

  task automatic check_block_const(input string name, input longint v);
    for (int c = 0; c < DCT_N; c++) check_vec(name, got[c], splat(v));
  endtask

  task automatic lane_reset(input logic new_lane);
    rst_n = 1'b0;
    lane  = new_lane;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic rand_rows(output vec_t rows[DCT_N]);
    for (int r = 0; r < DCT_N; r++) begin
      rows[r] = '0;
      for (int c = 0; c < DCT_N; c++) rows[r] = put(rows[r], c, longint'($urandom_range(0, 4000)) - 2000);
    end
  endtask

  initial begin
    vec_t rows[DCT_N];
    vec_t exp_col;
    int   cycles;

    // Reset: core_in_valid held low and in_ready tracks a toggling core_in_ready.
    in_valid  = 1'b1;
    stall_pct = 50;
    repeat (2) tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_int("reset_core_in_valid", m_core_in_valid, 0);
      check_int("reset_in_ready_follows", m_in_ready, core_in_ready);
      check_int("reset_busy", m_busy, 0);
      tick();
    end
    in_valid  = 1'b0;
    stall_pct = 0;
    tick();
    rst_n = 1'b1;
    tick();

    // Identity core, zero latency: issue and result handshakes overlap.
    for (int r = 0; r < DCT_N; r++) begin
      rows[r] = '0;
      for (int c = 0; c < DCT_N; c++) rows[r] = put(rows[r], c, 8 * r + c);
    end
    beats = 0;
    send_rows(rows, DCT_N, cycles);
    wait_drain();
    check_int("t1_beats", beats, 8);
    for (int c = 0; c < DCT_N; c++) begin
      exp_col = '0;
      for (int k = 0; k < DCT_N; k++) exp_col = put(exp_col, k, 8 * k + c);
      check_vec("t1_literal_col", got[c], exp_col);
    end

    // Deep core with long latency: 8 rows back-to-back, then stall with iss_cnt at 8.
    depth = 16; lat_min = 12; lat_max = 12;
    rand_rows(rows);
    beats = 0;
    send_rows(rows, DCT_N, cycles);
    check_int("t4_back_to_back_cycles", cycles, 8);
    in_valid = 1'b1;
    in_row   = splat(99);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_int("t4_core_ready_high", core_in_ready, 1);
      check_int("t4_in_ready_stalled", m_in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    wait_drain();
    check_int("t4_beats", beats, 8);

    // Downstream stall of 5 cycles on column 3.
    depth = 8; lat_min = 0; lat_max = 3;
    out_mode = 2; stall_left = 5; stall_armed = 1'b1; stall_cycles = 0;
    rand_rows(rows);
    beats = 0;
    send_rows(rows, DCT_N, cycles);
    wait_drain();
    check_int("t3_stall_cycles", stall_cycles, 5);
    check_int("t3_beats", beats, 8);
    out_mode = 0;

    // Reset after 4 rows; the following 8 rows form a fresh block.
    rand_rows(rows);
    send_rows(rows, 4, cycles);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int r = 0; r < DCT_N; r++) rows[r] = put(splat(r + 100), 0, 7 * r);
    beats = 0;
    send_rows(rows, DCT_N, cycles);
    wait_drain();
    check_int("t5_beats", beats, 8);
    check_vec("t5_col0_literal", got[0], {32'sd49, 32'sd42, 32'sd35, 32'sd28, 32'sd21, 32'sd14, 32'sd7, 32'sd0});
    check_vec("t5_col1_literal", got[1], {32'sd107, 32'sd106, 32'sd105, 32'sd104, 32'sd103, 32'sd102, 32'sd101, 32'sd100});

    // Real DCT core on a flat block of 16.
    core_dct = 1'b1;
    for (int r = 0; r < DCT_N; r++) rows[r] = splat(16);
    beats = 0;
    send_rows(rows, DCT_N, cycles);
    wait_drain();
    check_int("t6_beats", beats, 8);
    check_range("t6_dc", el(got[0], 0), 127, 129);
    for (int c = 0; c < DCT_N; c++)
      for (int k = 0; k < DCT_N; k++)
        if (c != 0 || k != 0) check_range("t6_ac", el(got[c], k), -1, 1);
    core_dct = 1'b0;

    // ROW_SHIFT=1 instance: 3 rounds to 2, -3 rounds to -1.
    lane_reset(1'b1);
    for (int r = 0; r < DCT_N; r++) rows[r] = splat(3);
    beats = 0;
    send_rows(rows, DCT_N, cycles);
    wait_drain();
    check_block_const("t2_pos_round", 2);
    for (int r = 0; r < DCT_N; r++) rows[r] = splat(-3);
    send_rows(rows, DCT_N, cycles);
    wait_drain();
    check_block_const("t2_neg_round", -1);
    check_int("t2_beats", beats, 16);

    // Randomised traffic on both instances.
    out_mode = 1; stall_pct = 20; lat_min = 0; lat_max = 3;
    for (int ln = 1; ln >= 0; ln--) begin
      lane_reset(ln[0]);
      beats = 0;
      for (int blk = 0; blk < 3; blk++) begin
        rand_rows(rows);
        send_rows(rows, DCT_N, cycles);
      end
      wait_drain();
      check_int("rand_beats", beats, 24);
    end
    out_mode = 0; stall_pct = 0;

    check_int("leftover_expected", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
